// File: rtl/state_sequencer_pkg.sv
// Shared encodings for the multi-cycle sequencer and the control unit that consumes its state codes.
package state_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'b000,
        ST_DECODE  = 3'b001,
        ST_EXECUTE = 3'b010,
        ST_MEM     = 3'b011,
        ST_WB      = 3'b100,
        ST_POP     = 3'b101
    } state_e;

    typedef enum logic [1:0] {
        IT_R = 2'b00,
        IT_I = 2'b01,
        IT_J = 2'b10,
        IT_S = 2'b11
    } inst_type_e;

    localparam logic [4:0] FN_J   = 5'd0;
    localparam logic [4:0] FN_JAL = 5'd1;
    localparam logic [4:0] FN_RET = 5'd2;
    localparam logic [4:0] FN_LW  = 5'd2;
    localparam logic [4:0] FN_SW  = 5'd3;
    localparam logic [4:0] FN_BEQ = 5'd4;

    // Highest defined function code for each instruction type
    localparam logic [4:0] R_FUNC_MAX = 5'd4;
    localparam logic [4:0] I_FUNC_MAX = 5'd4;
    localparam logic [4:0] J_FUNC_MAX = 5'd2;
    localparam logic [4:0] S_FUNC_MAX = 5'd3;

    function automatic logic func_illegal(input logic [1:0] t, input logic [4:0] f);
        logic bad;
        bad = 1'b0;
        case (t)
            IT_R:    bad = (f > R_FUNC_MAX);
            IT_I:    bad = (f > I_FUNC_MAX);
            IT_J:    bad = (f > J_FUNC_MAX);
            IT_S:    bad = (f > S_FUNC_MAX);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/state_sequencer_mem_wait_timer.sv
// Memory-wait counter shared by FETCH, MEM and POP; flags a timeout when the wait limit is hit with ready low.
module state_sequencer_mem_wait_timer #(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active_i,
    input  logic ready_i,
    output logic timeout_c_o
);

    localparam int unsigned CNT_BITS = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WAIT_LIMIT - 1);

    logic [CNT_BITS-1:0] cnt_q;
    logic [CNT_BITS-1:0] cnt_d;
    logic                stall;

    // Count only consecutive stalled cycles; ready, timeout or leaving the wait state clears it
    always_comb begin
        stall       = active_i & ~ready_i;
        timeout_c_o = stall & (cnt_q == LAST_CNT);
        cnt_d       = '0;
        if (stall && !timeout_c_o) begin
            cnt_d = cnt_q + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/state_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEM/WB with stop-bit POP and memory-wait timeout.
// Define STATE_SEQ_PERF_EN to add the cycle_count / inst_count performance counters.
module state_sequencer
    import state_sequencer_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 16
`ifdef STATE_SEQ_PERF_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       inst_type,
    input  logic [4:0]       inst_function,
    input  logic             stop_bit,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic [2:0]       state,
    output logic [2:0]       next_state,
    output logic             ir_load,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             inst_done,
    output logic             illegal,
`ifdef STATE_SEQ_PERF_EN
    output logic             bus_error,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] inst_count
`else
    output logic             bus_error
`endif
);

    state_e     state_q;
    state_e     state_d;
    logic [1:0] type_q;
    logic [4:0] func_q;
    logic       stop_q;

    logic       wait_active;
    logic       wait_ready;
    logic       timeout;
    logic       retire;
    logic       stop_sel;
    logic       lat_is_i;

    always_comb begin
        wait_active = (state_q == ST_FETCH) || (state_q == ST_MEM) || (state_q == ST_POP);
        wait_ready  = (state_q == ST_FETCH) ? imem_ready : dmem_ready;
    end

    state_sequencer_mem_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_mem_wait_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .active_i    (wait_active),
        .ready_i     (wait_ready),
        .timeout_c_o (timeout)
    );

    // Next-state and strobes; DECODE still sees the live IR, later states use the latched copy
    always_comb begin
        state_d   = ST_FETCH;
        ir_load   = 1'b0;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        inst_done = 1'b0;
        illegal   = 1'b0;
        bus_error = 1'b0;
        retire    = 1'b0;
        stop_sel  = stop_q;
        lat_is_i  = (type_q == IT_I);

        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    bus_error = 1'b1;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                stop_sel = stop_bit;
                if (func_illegal(inst_type, inst_function)) begin
                    illegal = 1'b1;
                end else if (inst_type == IT_J) begin
                    if (inst_function == FN_J) begin
                        retire = 1'b1;
                    end else if ((inst_function == FN_JAL) || (inst_function == FN_RET)) begin
                        state_d = ST_MEM;
                    end
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (lat_is_i && (func_q == FN_BEQ)) begin
                    retire = 1'b1;
                end else if (lat_is_i && ((func_q == FN_LW) || (func_q == FN_SW))) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    if (lat_is_i && (func_q == FN_LW)) begin
                        state_d = ST_WB;
                    end else begin
                        retire = 1'b1;
                    end
                end else if (timeout) begin
                    bus_error = 1'b1;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                retire = 1'b1;
            end
            ST_POP: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    state_d = ST_FETCH;
                end else if (timeout) begin
                    bus_error = 1'b1;
                end else begin
                    state_d = ST_POP;
                end
            end
            default: state_d = ST_FETCH;
        endcase

        if (retire) begin
            inst_done = 1'b1;
            state_d   = stop_sel ? ST_POP : ST_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            type_q  <= 2'b00;
            func_q  <= 5'd0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                type_q <= inst_type;
                func_q <= inst_function;
                stop_q <= stop_bit;
            end
        end
    end

    assign state      = state_q;
    assign next_state = state_d;

`ifdef STATE_SEQ_PERF_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] inst_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            inst_q  <= '0;
        end else begin
            cycle_q <= cycle_q + CNT_W'(1);
            if (inst_done) begin
                inst_q <= inst_q + CNT_W'(1);
            end
        end
    end

    assign cycle_count = cycle_q;
    assign inst_count  = inst_q;
`endif

endmodule

// File: tb/tb_state_sequencer.sv
// Directed bench for state_sequencer: per-cycle state/next_state/strobe vectors with hand-derived expectations.
module tb_state_sequencer;

    localparam logic [2:0] S_F = 3'd0;
    localparam logic [2:0] S_D = 3'd1;
    localparam logic [2:0] S_E = 3'd2;
    localparam logic [2:0] S_M = 3'd3;
    localparam logic [2:0] S_W = 3'd4;
    localparam logic [2:0] S_P = 3'd5;

    // Strobe order: ir_load, imem_req, dmem_req, inst_done, illegal, bus_error
    localparam logic [5:0] F_NONE = 6'b000000;
    localparam logic [5:0] F_IRL  = 6'b100000;
    localparam logic [5:0] F_IREQ = 6'b010000;
    localparam logic [5:0] F_DREQ = 6'b001000;
    localparam logic [5:0] F_DONE = 6'b000100;
    localparam logic [5:0] F_ILL  = 6'b000010;
    localparam logic [5:0] F_BERR = 6'b000001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] inst_type;
    logic [4:0] inst_function;
    logic       stop_bit;
    logic       imem_ready;
    logic       dmem_ready;
    logic [2:0] state;
    logic [2:0] next_state;
    logic       ir_load;
    logic       imem_req;
    logic       dmem_req;
    logic       inst_done;
    logic       illegal;
    logic       bus_error;
`ifdef STATE_SEQ_PERF_EN
    logic [31:0] cycle_count;
    logic [31:0] inst_count;
`endif

    logic [11:0] obs;
    int          n_vec = 0;
    int          n_err = 0;

    state_sequencer #(.WAIT_LIMIT(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inst_type     (inst_type),
        .inst_function (inst_function),
        .stop_bit      (stop_bit),
        .imem_ready    (imem_ready),
        .dmem_ready    (dmem_ready),
        .state         (state),
        .next_state    (next_state),
        .ir_load       (ir_load),
        .imem_req      (imem_req),
        .dmem_req      (dmem_req),
        .inst_done     (inst_done),
        .illegal       (illegal),
`ifdef STATE_SEQ_PERF_EN
        .bus_error     (bus_error),
        .cycle_count   (cycle_count),
        .inst_count    (inst_count)
`else
        .bus_error     (bus_error)
`endif
    );

    always #5 clk = ~clk;

    assign obs = {state, next_state, ir_load, imem_req, dmem_req, inst_done, illegal, bus_error};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ir(input logic [1:0] t, input logic [4:0] f, input logic s);
        inst_type     = t;
        inst_function = f;
        stop_bit      = s;
    endtask

    // Drive readies for one cycle, check the cycle's outputs, then advance past the edge
    task automatic step(input string tag, input logic ir, input logic dr,
                        input logic [2:0] es, input logic [2:0] ens, input logic [5:0] ef);
        imem_ready = ir;
        dmem_ready = dr;
        #1;
        check_eq(tag, 32'(obs), 32'({es, ens, ef}));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        set_ir(2'b00, 5'd0, 1'b0);
        #2;
        check_eq("reset", 32'(obs), 32'({S_F, S_F, F_IREQ}));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // R-type ADD; IR scrambled after DECODE to prove later states use latched fields
        set_ir(2'b00, 5'd1, 1'b0);
        step("add.F", 1, 0, S_F, S_D, F_IRL | F_IREQ);
        step("add.D", 0, 0, S_D, S_E, F_NONE);
        set_ir(2'b01, 5'd4, 1'b1);
        step("add.E", 0, 0, S_E, S_W, F_NONE);
        step("add.W", 0, 0, S_W, S_F, F_DONE);

        // LW with data memory ready on the fourth MEM cycle
        set_ir(2'b01, 5'd2, 1'b0);
        step("lw.F", 1, 0, S_F, S_D, F_IRL | F_IREQ);
        step("lw.D", 0, 0, S_D, S_E, F_NONE);
        set_ir(2'b00, 5'd7, 1'b1);
        step("lw.E", 0, 0, S_E, S_M, F_NONE);
        step("lw.M1", 0, 0, S_M, S_M, F_DREQ);
        step("lw.M2", 0, 0, S_M, S_M, F_DREQ);
        step("lw.M3", 0, 0, S_M, S_M, F_DREQ);
        step("lw.M4", 0, 1, S_M, S_W, F_DREQ);
        step("lw.W", 0, 0, S_W, S_F, F_DONE);

        // JAL with stop bit: retire in MEM, then POP
        set_ir(2'b10, 5'd1, 1'b1);
        step("jal.F", 1, 0, S_F, S_D, F_IRL | F_IREQ);
        step("jal.D", 0, 0, S_D, S_M, F_NONE);
        set_ir(2'b10, 5'd0, 1'b0);
        step("jal.M", 0, 1, S_M, S_P, F_DREQ | F_DONE);
        step("jal.P", 0, 1, S_P, S_F, F_DREQ);

        // Illegal functions at each type's boundary; stop bit must not cause POP
        set_ir(2'b00, 5'd7, 1'b1);
        step("ilr7.F", 1, 0, S_F, S_D, F_IRL | F_IREQ);
        step("ilr7.D", 0, 0, S_D, S_F, F_ILL);
        set_ir(2'b11, 5'd4, 1'b1);
        step("ils4.F", 1, 0, S_F, S_D, F_IRL | F_IREQ);
        step("ils4.D", 0, 0, S_D, S_F, F_ILL);
        set_ir(2'b10, 5'd3, 1'b0);
        step("ilj3.F", 1, 0, S_F, S_D, F_IRL | F_IREQ);
        step("ilj3.D", 0, 0, S_D, S_F, F_ILL);

        // S-type func 3 is the last legal S function
        set_ir(2'b11, 5'd3, 1'b0);
        step("s3.F", 1, 0, S_F, S_D, F_IRL | F_IREQ);
        step("s3.D", 0, 0, S_D, S_E, F_NONE);
        step("s3.E", 0, 0, S_E, S_W, F_NONE);
        step("s3.W", 0, 0, S_W, S_F, F_DONE);

        // J with stop bit: retires in DECODE then POP
        set_ir(2'b10, 5'd0, 1'b1);
        step("j.F", 1, 0, S_F, S_D, F_IRL | F_IREQ);
        step("j.D", 0, 0, S_D, S_P, F_DONE);
        step("j.P", 0, 1, S_P, S_F, F_DREQ);

        // BEQ; readies raised in DECODE and EXECUTE must be ignored
        set_ir(2'b01, 5'd4, 1'b0);
        step("beq.F", 1, 0, S_F, S_D, F_IRL | F_IREQ);
        step("beq.D", 1, 1, S_D, S_E, F_NONE);
        step("beq.E", 1, 1, S_E, S_F, F_DONE);

        set_ir(2'b01, 5'd3, 1'b0);
        step("sw.F", 1, 0, S_F, S_D, F_IRL | F_IREQ);
        step("sw.D", 0, 0, S_D, S_E, F_NONE);
        step("sw.E", 0, 0, S_E, S_M, F_NONE);
        step("sw.M", 0, 1, S_M, S_F, F_DREQ | F_DONE);

        set_ir(2'b10, 5'd2, 1'b0);
        step("ret.F", 1, 0, S_F, S_D, F_IRL | F_IREQ);
        step("ret.D", 0, 0, S_D, S_M, F_NONE);
        step("ret.M", 0, 1, S_M, S_F, F_DREQ | F_DONE);

        // Fetch timeout on 16th waiting cycle, then ready exactly at the limit wins
        for (int i = 1; i <= 15; i++) begin
            step($sformatf("fto.a%0d", i), 0, 0, S_F, S_F, F_IREQ);
        end
        step("fto.a16", 0, 0, S_F, S_F, F_IREQ | F_BERR);
        for (int i = 1; i <= 15; i++) begin
            step($sformatf("fto.b%0d", i), 0, 0, S_F, S_F, F_IREQ);
        end
        set_ir(2'b00, 5'd1, 1'b0);
        step("fto.b16", 1, 0, S_F, S_D, F_IRL | F_IREQ);
        step("fto.D", 0, 0, S_D, S_E, F_NONE);
        step("fto.E", 0, 0, S_E, S_W, F_NONE);
        step("fto.W", 0, 0, S_W, S_F, F_DONE);

        // MEM timeout for LW: bus_error, back to FETCH, no retire
        set_ir(2'b01, 5'd2, 1'b0);
        step("mto.F", 1, 0, S_F, S_D, F_IRL | F_IREQ);
        step("mto.D", 0, 0, S_D, S_E, F_NONE);
        step("mto.E", 0, 0, S_E, S_M, F_NONE);
        for (int i = 1; i <= 15; i++) begin
            step($sformatf("mto.m%0d", i), 0, 0, S_M, S_M, F_DREQ);
        end
        step("mto.m16", 0, 0, S_M, S_F, F_DREQ | F_BERR);
        step("mto.after", 0, 0, S_F, S_F, F_IREQ);

        // Asynchronous reset in the middle of a MEM access
        set_ir(2'b01, 5'd2, 1'b0);
        step("rstm.F", 1, 0, S_F, S_D, F_IRL | F_IREQ);
        step("rstm.D", 0, 0, S_D, S_E, F_NONE);
        step("rstm.E", 0, 0, S_E, S_M, F_NONE);
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        check_eq("rstm.pre", 32'({state, dmem_req}), 32'({S_M, 1'b1}));
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rstm.async", 32'({state, dmem_req}), 32'({S_F, 1'b0}));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_ir(2'b00, 5'd1, 1'b0);
        step("rstm.F2", 1, 0, S_F, S_D, F_IRL | F_IREQ);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
